program_loader: RTL and testbench
=================================

# program_loader

Boot-time program loader that sits directly upstream of the processor core's program memory and reset input. It receives a framed byte stream over a valid/ready handshake, assembles 13-bit instructions from byte pairs, writes them sequentially into program memory, and verifies an XOR checksum. It holds the core in reset while loading and releases it only after a verified load.

## Interface
- INS_WIDTH, 13, instruction width; must equal program-memory word width.
- ADDR_WIDTH, 6, program-memory address width.
- MEM_LEN, 64, maximum instruction count; must be ≤ 2^ADDR_WIDTH.

- clk  in  1  single clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle request to begin a load.
- ByteIn  in  8  stream data byte.
- ByteValid  in  1  ByteIn is valid.
- ByteReady  out  1  loader accepts a byte this cycle.
- PM_WE  out  1  program-memory write enable, one-cycle pulse per instruction.
- PM_Addr  out  ADDR_WIDTH  program-memory write address.
- PM_Data  out  INS_WIDTH  program-memory write data.
- CoreNReset  out  1  active-low reset to the core; 1 only in DONE.
- Busy  out  1  load in progress.
- Done  out  1  verified load complete.
- Error  out  1  load failed.

## Operation
- Frame: count byte N, then N pairs of (LO, HI), then checksum byte C.
- Instruction i = {HI[4:0], LO[7:0]} and is written to address i, for i = 0..N-1.
- C must equal the XOR of the count byte and all 2N data bytes.
- States: IDLE, COUNT, LO, HI, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + Start → COUNT. This clears the index and running XOR, and drops Done, Error and CoreNReset.
- COUNT, on accept:
  - N = 0 or N > MEM_LEN → ERROR.
  - Otherwise, latch N, XOR ← N, → LO.
- LO, on accept: latch the byte, XOR update, → HI.
- HI, on accept:
  - If HI[7:5] ≠ 0 → ERROR, with no write.
  - Otherwise: XOR update, register PM_Addr = index and PM_Data = assembled word, and pulse PM_WE.
  - If index = N-1 → CHECK; else index+1 and → LO.
- CHECK, on accept: C equals XOR → DONE; otherwise → ERROR.
- DONE and ERROR hold until Start or Reset.
- Start in COUNT/LO/HI/CHECK is ignored.
- Memory contents already written are never cleared, whether after an ERROR or a Reset.
- ByteReady = 1 exactly in COUNT, LO, HI and CHECK.
- Busy = ByteReady.
- Acceptance occurs when ByteValid & ByteReady are both high at a rising edge. ByteValid may deassert between bytes for any number of cycles (stall); state then holds.
- Index never wraps: the maximum address written is MEM_LEN-1.

## Timing
- Reset values: state IDLE; ByteReady 0, PM_WE 0, PM_Addr 0, PM_Data 0, CoreNReset 0, Busy 0, Done 0, Error 0.
- Reset mid-load: all of the above take effect at the next edge, and any pending PM_WE is cancelled.
- All outputs are registered; ByteReady is a decode of registered state.
- Start sampled at edge k → ByteReady = 1 from cycle k+1.
- Start and ByteValid in the same cycle in IDLE: Start acts, and the byte is not accepted.
- HI accepted at edge k → PM_WE = 1 for exactly cycle k+1, with PM_Addr/PM_Data valid in that same cycle.
- Throughput: one byte per cycle. A frame of N instructions with no stalls takes 2N+2 accept cycles.
- Checksum accepted at edge k → Done = 1 and CoreNReset = 1 from cycle k+1; Busy = 0 from cycle k+1.
- Error detected on the byte accepted at edge k → Error = 1 and ByteReady = 0 from cycle k+1.

## Test plan
- Normal load: Start; bytes 0x02, 0x34, 0x12, 0xAB, 0x05, 0x8A → PM_WE pulses with (addr 0, 0x1234) and (addr 1, 0x05AB); Done = 1, CoreNReset = 1, Error = 0.
- Bad checksum: same frame with final byte 0x8B → both writes occur; Error = 1, Done = 0, CoreNReset = 0; a new Start returns to COUNT.
- Bad count:
  - Count 0x00 → Error = 1 the next cycle.
  - Count 0x41 → Error = 1; no PM_WE in either case.
- Bad HI: Start, 0x01, 0x00, 0x20 → no PM_WE; Error = 1.
- Full memory: N = 0x40 with random words and random ByteValid stalls → 64 writes at addresses 0..63 in order, no wrap; Done = 1 with correct checksum.
- Reset mid-load: Reset asserted after the 3rd accepted byte → all outputs at reset values the next cycle; a following complete N = 1 load reaches DONE.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time program loader.
// Takes a framed byte stream (count, LO/HI pairs, checksum) over valid/ready,
// writes the assembled 13-bit instructions into program memory in order, and
// releases the core from reset only after the XOR checksum verifies.
module program_loader #(
  parameter int unsigned INS_WIDTH  = 13,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned MEM_LEN    = 64
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  PM_WE,
  output logic [ADDR_WIDTH-1:0] PM_Addr,
  output logic [INS_WIDTH-1:0]  PM_Data,
  output logic                  CoreNReset,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StLo,
    StHi,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  // Index of the final instruction (N-1); N <= MEM_LEN so it fits the address.
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [7:0]            xor_q, xor_d;
  logic [7:0]            lo_q, lo_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [INS_WIDTH-1:0]  data_q, data_d;

  logic byte_ready;
  logic accept;

  assign byte_ready = (state_q == StCount) || (state_q == StLo) ||
                      (state_q == StHi)    || (state_q == StCheck);
  assign accept     = ByteValid & byte_ready;

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      last_q  <= '0;
      xor_q   <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      xor_q   <= xor_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Frame parser: next state, running checksum and memory write request.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    xor_d   = xor_q;
    lo_d    = lo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    unique case (state_q)
      StIdle, StDone, StError: begin
        // A byte presented alongside Start is not accepted: ready is low here.
        if (Start) begin
          state_d = StCount;
          idx_d   = '0;
          xor_d   = '0;
        end
      end
      StCount: begin
        if (accept) begin
          if ((ByteIn == 8'd0) || (32'(ByteIn) > MEM_LEN)) begin
            state_d = StError;
          end else begin
            last_d  = ADDR_WIDTH'(ByteIn - 8'd1);
            xor_d   = ByteIn;
            state_d = StLo;
          end
        end
      end
      StLo: begin
        if (accept) begin
          lo_d    = ByteIn;
          xor_d   = xor_q ^ ByteIn;
          state_d = StHi;
        end
      end
      StHi: begin
        if (accept) begin
          if (ByteIn[7:5] != 3'b000) begin
            state_d = StError;
          end else begin
            xor_d  = xor_q ^ ByteIn;
            we_d   = 1'b1;
            addr_d = idx_q;
            data_d = INS_WIDTH'({ByteIn[4:0], lo_q});
            if (idx_q == last_q) begin
              state_d = StCheck;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = StLo;
            end
          end
        end
      end
      StCheck: begin
        if (accept) begin
          state_d = (ByteIn == xor_q) ? StDone : StError;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ByteReady  = byte_ready;
  assign Busy       = byte_ready;
  assign Done       = (state_q == StDone);
  assign CoreNReset = (state_q == StDone);
  assign Error      = (state_q == StError);
  assign PM_WE      = we_q;
  assign PM_Addr    = addr_q;
  assign PM_Data    = data_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a frame-position reference model
// checked every cycle, directed frames with literal expectations, and
// randomized frames with random stalls and corruptions.
module tb_program_loader;

  localparam int unsigned INS_WIDTH  = 13;
  localparam int unsigned ADDR_WIDTH = 6;
  localparam int unsigned MEM_LEN    = 64;

  logic                  clk = 1'b0;
  logic                  Reset;
  logic                  Start;
  logic [7:0]            ByteIn;
  logic                  ByteValid;
  logic                  ByteReady;
  logic                  PM_WE;
  logic [ADDR_WIDTH-1:0] PM_Addr;
  logic [INS_WIDTH-1:0]  PM_Data;
  logic                  CoreNReset;
  logic                  Busy;
  logic                  Done;
  logic                  Error;

  program_loader #(
    .INS_WIDTH (INS_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_LEN   (MEM_LEN)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Start     (Start),
    .ByteIn    (ByteIn),
    .ByteValid (ByteValid),
    .ByteReady (ByteReady),
    .PM_WE     (PM_WE),
    .PM_Addr   (PM_Addr),
    .PM_Data   (PM_Data),
    .CoreNReset(CoreNReset),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks position within the frame rather than any state encoding.
  bit                    m_busy, m_done, m_err, m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [INS_WIDTH-1:0]  m_data;
  int                    m_pos, m_n;
  logic [7:0]            m_acc, m_lo;

  always @(posedge clk) begin
    if (Reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_err  <= 1'b0;
      m_we   <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
    end else begin
      m_we <= 1'b0;
      if (!m_busy) begin
        if (Start) begin
          m_busy <= 1'b1;
          m_done <= 1'b0;
          m_err  <= 1'b0;
          m_pos  <= 0;
          m_acc  <= 8'h00;
        end
      end else if (ByteValid) begin
        m_pos <= m_pos + 1;
        if (m_pos == 0) begin
          if (ByteIn == 8'h00 || int'(ByteIn) > int'(MEM_LEN)) begin
            m_busy <= 1'b0;
            m_err  <= 1'b1;
          end else begin
            m_n   <= int'(ByteIn);
            m_acc <= ByteIn;
          end
        end else if (m_pos <= 2 * m_n) begin
          if (m_pos % 2 == 1) begin
            m_lo  <= ByteIn;
            m_acc <= m_acc ^ ByteIn;
          end else if (ByteIn[7:5] != 3'b000) begin
            m_busy <= 1'b0;
            m_err  <= 1'b1;
          end else begin
            m_acc  <= m_acc ^ ByteIn;
            m_we   <= 1'b1;
            m_addr <= ADDR_WIDTH'(m_pos / 2 - 1);
            m_data <= {ByteIn[4:0], m_lo};
          end
        end else begin
          if (ByteIn == m_acc) m_done <= 1'b1;
          else m_err <= 1'b1;
          m_busy <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ByteReady", 32'(ByteReady), 32'(m_busy));
      chk("Busy", 32'(Busy), 32'(m_busy));
      chk("Done", 32'(Done), 32'(m_done));
      chk("Error", 32'(Error), 32'(m_err));
      chk("CoreNReset", 32'(CoreNReset), 32'(m_done));
      chk("PM_WE", 32'(PM_WE), 32'(m_we));
      if (m_we) begin
        chk("PM_Addr", 32'(PM_Addr), 32'(m_addr));
        chk("PM_Data", 32'(PM_Data), 32'(m_data));
      end
    end
  end

  // Write log for the literal expectations.
  logic [ADDR_WIDTH-1:0] wr_addr[$];
  logic [INS_WIDTH-1:0]  wr_data[$];

  always @(negedge clk) begin
    if (PM_WE) begin
      wr_addr.push_back(PM_Addr);
      wr_data.push_back(PM_Data);
    end
  end

  logic [7:0]           frame[$];
  logic [INS_WIDTH-1:0] words[$];

  // All driver tasks start and end just after a falling edge.
  task automatic pulse_start(input bit with_valid);
    Start = 1'b1;
    if (with_valid) begin
      ByteValid = 1'b1;
      ByteIn    = 8'($urandom);
    end
    @(negedge clk);
    Start     = 1'b0;
    ByteValid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int max_stall, input bit noise);
    int stall;
    int guard;
    bit acc;
    stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
    repeat (stall) begin
      ByteValid = 1'b0;
      ByteIn    = 8'($urandom);
      Start     = noise && ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    Start     = 1'b0;
    ByteValid = 1'b1;
    ByteIn    = b;
    guard     = 0;
    acc       = 1'b0;
    while (!acc && guard < 50) begin
      acc = ByteReady;
      @(negedge clk);
      guard++;
    end
    chk("byte accepted", 32'(acc), 32'(1));
    ByteValid = 1'b0;
  endtask

  task automatic send_frame(input int len, input int max_stall, input bit noise);
    for (int i = 0; i < len; i++) send(frame[i], max_stall, noise);
  endtask

  task automatic build_good(input int n);
    logic [7:0] cs, lo, hi;
    frame.delete();
    words.delete();
    frame.push_back(8'(n));
    cs = 8'(n);
    for (int i = 0; i < n; i++) begin
      lo = 8'($urandom);
      hi = {3'b000, 5'($urandom)};
      frame.push_back(lo);
      frame.push_back(hi);
      words.push_back({hi[4:0], lo});
      cs = cs ^ lo ^ hi;
    end
    frame.push_back(cs);
  endtask

  task automatic load_literal(input logic [7:0] cs);
    frame.delete();
    frame.push_back(8'h02);
    frame.push_back(8'h34);
    frame.push_back(8'h12);
    frame.push_back(8'hAB);
    frame.push_back(8'h05);
    frame.push_back(cs);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " ByteReady"}, 32'(ByteReady), 32'(0));
    chk({tag, " PM_WE"}, 32'(PM_WE), 32'(0));
    chk({tag, " PM_Addr"}, 32'(PM_Addr), 32'(0));
    chk({tag, " PM_Data"}, 32'(PM_Data), 32'(0));
    chk({tag, " CoreNReset"}, 32'(CoreNReset), 32'(0));
    chk({tag, " Busy"}, 32'(Busy), 32'(0));
    chk({tag, " Done"}, 32'(Done), 32'(0));
    chk({tag, " Error"}, 32'(Error), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind, n, j, len;
    Reset     = 1'b1;
    Start     = 1'b0;
    ByteValid = 1'b0;
    ByteIn    = 8'h00;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check_reset_outputs("reset");
    Reset = 1'b0;
    @(negedge clk);

    // Normal two-instruction load.
    wr_addr.delete(); wr_data.delete();
    pulse_start(1'b1);
    chk("ready after start", 32'(ByteReady), 32'(1));
    load_literal(8'h8A);
    send_frame(6, 0, 1'b0);
    chk("normal Done", 32'(Done), 32'(1));
    chk("normal CoreNReset", 32'(CoreNReset), 32'(1));
    chk("normal Error", 32'(Error), 32'(0));
    chk("normal Busy", 32'(Busy), 32'(0));
    chk("normal writes", 32'(wr_addr.size()), 32'(2));
    if (wr_addr.size() == 2) begin
      chk("normal addr0", 32'(wr_addr[0]), 32'(0));
      chk("normal data0", 32'(wr_data[0]), 32'h1234);
      chk("normal addr1", 32'(wr_addr[1]), 32'(1));
      chk("normal data1", 32'(wr_data[1]), 32'h05AB);
    end

    // Bad checksum: both writes still happen.
    wr_addr.delete(); wr_data.delete();
    pulse_start(1'b0);
    load_literal(8'h8B);
    send_frame(6, 0, 1'b0);
    chk("badcs Error", 32'(Error), 32'(1));
    chk("badcs Done", 32'(Done), 32'(0));
    chk("badcs CoreNReset", 32'(CoreNReset), 32'(0));
    chk("badcs writes", 32'(wr_addr.size()), 32'(2));

    // Restart from ERROR, then count zero.
    wr_addr.delete(); wr_data.delete();
    pulse_start(1'b0);
    chk("restart ready", 32'(ByteReady), 32'(1));
    chk("restart Error cleared", 32'(Error), 32'(0));
    send(8'h00, 0, 1'b0);
    chk("count0 Error", 32'(Error), 32'(1));

    // Count over MEM_LEN.
    pulse_start(1'b0);
    send(8'h41, 0, 1'b0);
    chk("count65 Error", 32'(Error), 32'(1));
    chk("badcount writes", 32'(wr_addr.size()), 32'(0));

    // Bad HI byte.
    pulse_start(1'b0);
    send(8'h01, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    send(8'h20, 0, 1'b0);
    chk("badhi Error", 32'(Error), 32'(1));
    chk("badhi writes", 32'(wr_addr.size()), 32'(0));

    // Full memory with stalls and ignored Start pulses.
    wr_addr.delete(); wr_data.delete();
    build_good(64);
    pulse_start(1'b0);
    send_frame(frame.size(), 3, 1'b1);
    chk("full Done", 32'(Done), 32'(1));
    chk("full writes", 32'(wr_addr.size()), 32'(64));
    if (wr_addr.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        chk("full addr", 32'(wr_addr[i]), 32'(i));
        chk("full data", 32'(wr_data[i]), 32'(words[i]));
      end
    end

    // Reset after the third accepted byte, then a clean single-word load.
    pulse_start(1'b0);
    send(8'h02, 0, 1'b0);
    send(8'h11, 0, 1'b0);
    send(8'h03, 0, 1'b0);
    Reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    Reset = 1'b0;
    wr_addr.delete(); wr_data.delete();
    frame.delete();
    frame.push_back(8'h01);
    frame.push_back(8'h55);
    frame.push_back(8'h1A);
    frame.push_back(8'h4E);
    pulse_start(1'b0);
    send_frame(4, 1, 1'b0);
    chk("postreset Done", 32'(Done), 32'(1));
    chk("postreset writes", 32'(wr_addr.size()), 32'(1));
    if (wr_addr.size() == 1) chk("postreset data", 32'(wr_data[0]), 32'h1A55);

    // Randomized frames, some corrupted.
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 8));
      build_good(n);
      len = frame.size();
      if (kind == 1) begin
        frame[0] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(65, 255));
        len = 1;
      end else if (kind == 2) begin
        j = int'($urandom_range(0, n - 1));
        frame[2 + 2 * j][7:5] = 3'($urandom_range(1, 7));
        len = 3 + 2 * j;
      end else if (kind == 3) begin
        frame[len - 1] = frame[len - 1] ^ 8'($urandom_range(1, 255));
      end
      pulse_start(1'b1);
      send_frame(len, 2, 1'b1);
      chk("random Error", 32'(Error), 32'(kind != 0));
      chk("random Done", 32'(Done), 32'(kind == 0));
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
